// File: rtl/buttons_res_core.sv
// Elevator request latches: in-car, hall-up and hall-down, set by button, cleared by inactivate.
// Define BUTTONS_RES_EDGE_DETECT_EN to set latches on button rising edges instead of levels.
module buttons_res_core #(
  parameter int BUTTONS_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [BUTTONS_WIDTH-1:0] btn_in,
  input  logic [BUTTONS_WIDTH-2:0] btn_up_out,
  input  logic [BUTTONS_WIDTH-1:1] btn_down_out,
  input  logic [BUTTONS_WIDTH-1:0] inactivate_in_levels,
  input  logic [BUTTONS_WIDTH-2:0] inactivate_out_up_levels,
  input  logic [BUTTONS_WIDTH-1:1] inactivate_out_down_levels,
  output logic [BUTTONS_WIDTH-1:0] active_in_levels,
  output logic [BUTTONS_WIDTH-2:0] active_out_up_levels,
  output logic [BUTTONS_WIDTH-1:1] active_out_down_levels
);

  logic [BUTTONS_WIDTH-1:0] set_in;
  logic [BUTTONS_WIDTH-2:0] set_up;
  logic [BUTTONS_WIDTH-1:1] set_down;

`ifdef BUTTONS_RES_EDGE_DETECT_EN
  logic [BUTTONS_WIDTH-1:0] prev_in;
  logic [BUTTONS_WIDTH-2:0] prev_up;
  logic [BUTTONS_WIDTH-1:1] prev_down;

  // History starts at 0, so a button held across reset counts as a press
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_in   <= '0;
      prev_up   <= '0;
      prev_down <= '0;
    end else begin
      prev_in   <= btn_in;
      prev_up   <= btn_up_out;
      prev_down <= btn_down_out;
    end
  end

  assign set_in   = btn_in & ~prev_in;
  assign set_up   = btn_up_out & ~prev_up;
  assign set_down = btn_down_out & ~prev_down;
`else
  assign set_in   = btn_in;
  assign set_up   = btn_up_out;
  assign set_down = btn_down_out;
`endif

  // Inactivate wins over a same-edge set
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      active_in_levels       <= '0;
      active_out_up_levels   <= '0;
      active_out_down_levels <= '0;
    end else begin
      active_in_levels <=
        (active_in_levels | set_in)
        & ~inactivate_in_levels;
      active_out_up_levels <=
        (active_out_up_levels | set_up)
        & ~inactivate_out_up_levels;
      active_out_down_levels <=
        (active_out_down_levels | set_down)
        & ~inactivate_out_down_levels;
    end
  end

endmodule

// File: tb/tb_buttons_res_core.sv
// Bench for buttons_res_core: vector table plus reset, walking and held-button sequences.
// Expected outputs flow through a scoreboard queue.
module tb_buttons_res_core;

  localparam int W = 8;

  logic         clock;
  logic         reset;
  logic [W-1:0] btn_in;
  logic [W-2:0] btn_up_out;
  logic [W-1:1] btn_down_out;
  logic [W-1:0] inactivate_in_levels;
  logic [W-2:0] inactivate_out_up_levels;
  logic [W-1:1] inactivate_out_down_levels;
  logic [W-1:0] active_in_levels;
  logic [W-2:0] active_out_up_levels;
  logic [W-1:1] active_out_down_levels;

  buttons_res_core #(.BUTTONS_WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .btn_in(btn_in),
    .btn_up_out(btn_up_out),
    .btn_down_out(btn_down_out),
    .inactivate_in_levels(inactivate_in_levels),
    .inactivate_out_up_levels(inactivate_out_up_levels),
    .inactivate_out_down_levels(inactivate_out_down_levels),
    .active_in_levels(active_in_levels),
    .active_out_up_levels(active_out_up_levels),
    .active_out_down_levels(active_out_down_levels)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] bi;
    logic [6:0] bu;
    logic [6:0] bd;
    logic [7:0] ii;
    logic [6:0] iu;
    logic [6:0] id;
    logic [7:0] ei;
    logic [6:0] eu;
    logic [6:0] ed;
  } vec_t;

  typedef struct packed {
    logic [7:0] ei;
    logic [6:0] eu;
    logic [6:0] ed;
  } exp_t;

  exp_t sb[$];
  int   n_vec;
  int   n_bad;
  logic [7:0] acc;
  logic [7:0] held_exp;

  task automatic drive(input logic [7:0] bi,
                       input logic [6:0] bu,
                       input logic [6:0] bd,
                       input logic [7:0] ii,
                       input logic [6:0] iu,
                       input logic [6:0] id);
    btn_in                     = bi;
    btn_up_out                 = bu;
    btn_down_out               = bd;
    inactivate_in_levels       = ii;
    inactivate_out_up_levels   = iu;
    inactivate_out_down_levels = id;
  endtask

  task automatic push(input logic [7:0] ei,
                      input logic [6:0] eu,
                      input logic [6:0] ed);
    exp_t e;
    e.ei = ei;
    e.eu = eu;
    e.ed = ed;
    sb.push_back(e);
  endtask

  task automatic compare(input string name);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      if (active_in_levels !== e.ei ||
          active_out_up_levels !== e.eu ||
          active_out_down_levels !== e.ed) begin
        n_bad++;
        $display("FAIL %s: got in=%h up=%h dn=%h want in=%h up=%h dn=%h",
                 name, active_in_levels, active_out_up_levels,
                 active_out_down_levels, e.ei, e.eu, e.ed);
      end
    end
  endtask

  task automatic tick(input string name);
    @(posedge clock);
    #1;
    compare(name);
  endtask

  vec_t tbl[12];

  initial begin
    n_vec = 0;
    n_bad = 0;

    // down group first, from a clean state
    tbl[0]  = '{8'h00, 7'h00, 7'h7F, 8'h00, 7'h00, 7'h00,
                8'h00, 7'h00, 7'h7F};
    tbl[1]  = '{8'h00, 7'h00, 7'h00, 8'h00, 7'h00, 7'h08,
                8'h00, 7'h00, 7'h77};
    tbl[2]  = '{8'h00, 7'h00, 7'h00, 8'h00, 7'h00, 7'h7F,
                8'h00, 7'h00, 7'h00};
    tbl[3]  = '{8'h81, 7'h00, 7'h00, 8'h00, 7'h00, 7'h00,
                8'h81, 7'h00, 7'h00};
    tbl[4]  = '{8'h04, 7'h00, 7'h00, 8'h00, 7'h00, 7'h00,
                8'h85, 7'h00, 7'h00};
    tbl[5]  = '{8'h00, 7'h00, 7'h00, 8'h04, 7'h00, 7'h00,
                8'h81, 7'h00, 7'h00};
    tbl[6]  = '{8'h81, 7'h00, 7'h00, 8'h00, 7'h00, 7'h00,
                8'h81, 7'h00, 7'h00};
    tbl[7]  = '{8'h00, 7'h08, 7'h00, 8'h00, 7'h08, 7'h00,
                8'h81, 7'h00, 7'h00};
    tbl[8]  = '{8'h00, 7'h7F, 7'h00, 8'h00, 7'h00, 7'h00,
                8'h81, 7'h7F, 7'h00};
    tbl[9]  = '{8'h00, 7'h08, 7'h00, 8'h00, 7'h08, 7'h00,
                8'h81, 7'h77, 7'h00};
    tbl[10] = '{8'h00, 7'h00, 7'h00, 8'h00, 7'h00, 7'h00,
                8'h81, 7'h77, 7'h00};
    tbl[11] = '{8'h00, 7'h00, 7'h00, 8'hFF, 7'h7F, 7'h7F,
                8'h00, 7'h00, 7'h00};

    // reset with arbitrary inputs: zero before any edge
    reset = 1'b0;
    drive($urandom, $urandom, $urandom,
          $urandom, $urandom, $urandom);
    #2;
    push(8'h00, 7'h00, 7'h00);
    compare("rst_async");
    drive(8'hFF, 7'h7F, 7'h7F, 8'h00, 7'h00, 7'h00);
    push(8'h00, 7'h00, 7'h00);
    tick("rst_ignore");

    // button held across release is a press
    drive(8'h02, 7'h00, 7'h00, 8'h00, 7'h00, 7'h00);
    reset = 1'b1;
    push(8'h02, 7'h00, 7'h00);
    tick("held_release");
    drive(8'h00, 7'h00, 7'h00, 8'hFF, 7'h7F, 7'h7F);
    push(8'h00, 7'h00, 7'h00);
    tick("clear_all");

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].bi, tbl[i].bu, tbl[i].bd,
            tbl[i].ii, tbl[i].iu, tbl[i].id);
      push(tbl[i].ei, tbl[i].eu, tbl[i].ed);
      tick($sformatf("vec%0d", i));
    end

    // walking in-car press
    acc = 8'h00;
    for (int k = 0; k < 8; k++) begin
      acc[k] = 1'b1;
      for (int c = 0; c < 5; c++) begin
        drive(8'h01 << k, 7'h00, 7'h00,
              8'h00, 7'h00, 7'h00);
        push(acc, 7'h00, 7'h00);
        tick($sformatf("walk%0d_%0d", k, c));
      end
    end

    // mid-operation reset, between edges
    drive(8'h00, 7'h7F, 7'h00, 8'h00, 7'h00, 7'h00);
    push(8'hFF, 7'h7F, 7'h00);
    tick("pre_rst");
    #2;
    reset = 1'b0;
    #1;
    push(8'h00, 7'h00, 7'h00);
    compare("rst_mid");
    drive(8'h00, 7'h00, 7'h00, 8'h00, 7'h00, 7'h00);
    push(8'h00, 7'h00, 7'h00);
    tick("rst_hold");
    reset = 1'b1;
    push(8'h00, 7'h00, 7'h00);
    tick("rst_done");

    // held button through a one-cycle inactivate
    drive(8'h20, 7'h00, 7'h00, 8'h00, 7'h00, 7'h00);
    push(8'h20, 7'h00, 7'h00);
    tick("held_set");
    drive(8'h20, 7'h00, 7'h00, 8'h20, 7'h00, 7'h00);
    push(8'h00, 7'h00, 7'h00);
    tick("held_clr");
`ifdef BUTTONS_RES_EDGE_DETECT_EN
    held_exp = 8'h00;
`else
    held_exp = 8'h20;
`endif
    drive(8'h20, 7'h00, 7'h00, 8'h00, 7'h00, 7'h00);
    push(held_exp, 7'h00, 7'h00);
    tick("held_after");
    push(held_exp, 7'h00, 7'h00);
    tick("held_after2");
    drive(8'h00, 7'h00, 7'h00, 8'h00, 7'h00, 7'h00);
    push(held_exp, 7'h00, 7'h00);
    tick("held_release_btn");
    drive(8'h20, 7'h00, 7'h00, 8'h00, 7'h00, 7'h00);
    push(8'h20, 7'h00, 7'h00);
    tick("held_repress");

    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover: got %0d entries want 0",
               sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
